// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: read-return owner encoding and
// the width of the starvation counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);

  logic              core_req;
  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              ext_req;
  logic              ext_wr;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_wr, core_addr, core_wdata,
    output core_stall, core_rvalid, core_rdata,
    input  ext_req, ext_wr, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_wr, mem_rd, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_wr, core_addr, core_wdata,
    input  core_stall, core_rvalid, core_rdata,
    output ext_req, ext_wr, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_wr, mem_rd, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_prio.sv
// Grant decision for the two requesters: core wins by default, but the
// external port is forced a slot after MAX_BURST consecutive contested losses.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic core_req,
  input  logic ext_req,
  output logic core_grant,
  output logic ext_grant
);

  localparam logic [STARVE_W-1:0] BURST_LIMIT = STARVE_W'(MAX_BURST);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  assign starved = (starve_cnt == BURST_LIMIT);

  // Reset masks both grants so nothing reaches the memory while it is held.
  always_comb begin
    ext_grant  = 1'b0;
    core_grant = 1'b0;
    if (reset) begin
      ext_grant  = ext_req & (~core_req | starved);
      core_grant = core_req & ~ext_grant;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!ext_req || ext_grant) begin
      starve_cnt <= '0;
    end else if (core_grant && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory: issues one
// access per cycle and routes the one-cycle-latency read data to its issuer.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  logic   core_grant;
  logic   ext_grant;
  owner_t rd_owner;
  owner_t rd_owner_next;

  dmem_arb_prio #(
    .MAX_BURST (MAX_BURST)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .core_req   (bus.core_req),
    .ext_req    (bus.ext_req),
    .core_grant (core_grant),
    .ext_grant  (ext_grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= rd_owner_next;
    end
  end

  // Issue mux; the next read owner is whoever issued a read this cycle.
  always_comb begin
    bus.mem_wr     = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    rd_owner_next  = OWN_NONE;
    if (core_grant) begin
      bus.mem_wr    = bus.core_wr;
      bus.mem_rd    = ~bus.core_wr;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
      if (!bus.core_wr) rd_owner_next = OWN_CORE;
    end else if (ext_grant) begin
      bus.mem_wr    = bus.ext_wr;
      bus.mem_rd    = ~bus.ext_wr;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
      if (!bus.ext_wr) rd_owner_next = OWN_EXT;
    end
  end

  always_comb begin
    bus.core_stall  = bus.core_req & ~core_grant & reset;
    bus.ext_gnt     = ext_grant;
    bus.core_rvalid = (rd_owner == OWN_CORE);
    bus.ext_rvalid  = (rd_owner == OWN_EXT);
    bus.core_rdata  = (rd_owner == OWN_CORE) ? bus.mem_rdata : '0;
    bus.ext_rdata   = (rd_owner == OWN_EXT)  ? bus.mem_rdata : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory (9-bit word address, 32-bit data) behind the core's MEM stage.
- Requester 0 is the pipeline MEM stage. Requester 1 is an external loader/debug port.
- Issues at most one access per cycle and stalls the pipeline when it loses arbitration.
- Routes the one-cycle-latency read data back to whichever requester issued the read.
- Bounded-starvation fixed priority: the core wins by default, but the external port is guaranteed a slot after MAX_BURST consecutive contested core grants.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 9, word address width.
- MAX_BURST, 4, consecutive contested core grants before the external port is forced a slot; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; held stable while core_stall=1.
- core_wr  in  1  1=write, 0=read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_stall  out  1  core_req=1 and not granted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_W  core read data.
- ext_req  in  1  external request; held stable until ext_gnt.
- ext_wr  in  1  1=write, 0=read.
- ext_addr  in  ADDR_W  external address.
- ext_wdata  in  DATA_W  external write data.
- ext_gnt  out  1  external access issued this cycle.
- ext_rvalid  out  1  external read data valid.
- ext_rdata  out  DATA_W  external read data.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_rd.

Behaviour:
- Grant decision is combinational within the cycle; there is no issue latency.
  - Neither requesting: no grant, mem_rd=mem_wr=0.
  - Only core: core granted.
  - Only ext: ext granted.
  - Both: ext granted iff starve_cnt==MAX_BURST, else core.
- starve_cnt (4-bit):
  - +1 on every cycle both request and core wins.
  - Cleared on any ext grant.
  - Also cleared on any cycle ext_req=0.
  - Saturates at MAX_BURST.
  - MAX_BURST=1 gives strict alternation under continuous contention.
- Issue outputs:
  - mem_addr and mem_wdata mux from the granted requester.
  - mem_wr = granted & wr; mem_rd = granted & ~wr.
  - Non-granted cycle: mem_addr=0, mem_wdata=0.
- core_stall = core_req & ~core_grant.
- ext_gnt = ext_grant. ext_gnt is a single-cycle pulse per access; the external port deasserts or advances ext_req the following cycle.
- Read-return FSM, rd_owner ∈ {NONE, CORE, EXT}; next state = owner of the read issued this cycle, NONE if no read.
  - rd_owner==CORE: core_rvalid=1, core_rdata=mem_rdata.
  - rd_owner==EXT: ext_rvalid=1, ext_rdata=mem_rdata.
  - Non-valid rdata outputs are driven 0.
- Back-to-back reads of alternating owners are legal; each return is routed independently, one per cycle.
- Writes produce no rvalid.
- Reset (reset=0), asynchronously and for as long as it is held:
  - rd_owner=NONE, starve_cnt=0.
  - All grants forced off: mem_rd=mem_wr=0, ext_gnt=0, core_stall=0.
  - rvalids=0, all data outputs 0.
- Reset during an outstanding read: the return is dropped and no rvalid is ever produced for it.
- Read-after-write to the same address in consecutive cycles returns the new data; this is the memory's responsibility, and the arbiter adds no forwarding.
- No internal queue. Requests are never buffered; the losing requester holds its request.

Decomposition:
- Shared package dmem_arb_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CORE, OWN_EXT}.
  - Localparam STARVE_W=4.
- Sub-module dmem_arb_prio: combinational grant logic plus the starve_cnt register.
  - Outputs core_grant and ext_grant.
- Top dmem_arbiter holds the issue mux, rd_owner FSM and return routing.
- Expected total size ~150–220 lines.

Test Plan:
- Reset release; core read addr 0x010 alone → mem_rd=1, mem_addr=0x010, core_stall=0 same cycle. Memory returns 0xDEADBEEF → core_rvalid=1, core_rdata=0xDEADBEEF next cycle; ext_rvalid=0.
- Ext write 0x1FF/0x12345678 with core idle → ext_gnt=1, mem_wr=1, mem_addr=0x1FF, mem_wdata=0x12345678; no rvalid either side.
- Continuous core_req and ext_req, MAX_BURST=4 → grant pattern C,C,C,C,E repeating. core_stall=1 exactly on E cycles; starve_cnt 0→4 then cleared.
- MAX_BURST=1, continuous contention → strict alternation C,E,C,E; alternating reads return to correct owners on consecutive cycles with distinct data 0xA/0xB.
- Core read issued, reset pulsed low next cycle → core_rvalid stays 0, all strobes 0 during reset; first post-reset request granted normally.
- ext_req dropped after 3 contested core grants, reasserted → starve_cnt cleared; ext waits a full 4 contested cycles again.
